// File: rtl/forwarding_unit.sv
// EX-stage forwarding unit: combinational ALU operand selects plus optional
// forwarding-event counters, compiled in when FORWARDING_PERF_CNT_EN is defined.

module forwarding_sel #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic [REG_ADDR_W-1:0] exmem_rd_i,
    input  logic [REG_ADDR_W-1:0] memwb_rd_i,
    input  logic                  exmem_we_i,
    input  logic                  memwb_we_i,
    output logic [1:0]            sel_o
);
    logic ex_hit, mem_hit;

    assign ex_hit  = exmem_we_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i);
    assign mem_hit = memwb_we_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i);

    // The younger producer (EX/MEM) wins a double hazard.
    assign sel_o = ex_hit ? 2'b10 : (mem_hit ? 2'b01 : 2'b00);
endmodule

module forwarding_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] IDEX_rs,
    input  logic [REG_ADDR_W-1:0] IDEX_rt,
    input  logic [REG_ADDR_W-1:0] EXMEM_rd,
    input  logic [REG_ADDR_W-1:0] MEMWB_rd,
    input  logic                  EXMEM_RegWrite,
    input  logic                  MEMWB_RegWrite,
    input  logic                  cnt_en,
    input  logic                  cnt_clr,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB,
    output logic [CNT_W-1:0]      ex_fwd_cnt,
    output logic [CNT_W-1:0]      mem_fwd_cnt
);
    logic [1:0][REG_ADDR_W-1:0] src;
    logic [1:0][1:0]            sel;

    assign src = {IDEX_rt, IDEX_rs};

    for (genvar g = 0; g < 2; g++) begin : g_op
        forwarding_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel (
            .src_i      (src[g]),
            .exmem_rd_i (EXMEM_rd),
            .memwb_rd_i (MEMWB_rd),
            .exmem_we_i (EXMEM_RegWrite),
            .memwb_we_i (MEMWB_RegWrite),
            .sel_o      (sel[g])
        );
    end

    assign ForwardA = sel[0];
    assign ForwardB = sel[1];

`ifdef FORWARDING_PERF_CNT_EN
    logic [CNT_W-1:0] ex_cnt_q, ex_cnt_d, mem_cnt_q, mem_cnt_d;
    logic [1:0]       ex_inc, mem_inc;

    // One extra sum bit catches overflow; at most +2 onto all-ones still fits.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W+1)'(inc);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    always_comb begin
        ex_inc    = {1'b0, sel[0] == 2'b10} + {1'b0, sel[1] == 2'b10};
        mem_inc   = {1'b0, sel[0] == 2'b01} + {1'b0, sel[1] == 2'b01};
        ex_cnt_d  = ex_cnt_q;
        mem_cnt_d = mem_cnt_q;
        if (cnt_clr) begin
            ex_cnt_d  = '0;
            mem_cnt_d = '0;
        end else if (cnt_en) begin
            ex_cnt_d  = sat_add(ex_cnt_q, ex_inc);
            mem_cnt_d = sat_add(mem_cnt_q, mem_inc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_cnt_q  <= '0;
            mem_cnt_q <= '0;
        end else begin
            ex_cnt_q  <= ex_cnt_d;
            mem_cnt_q <= mem_cnt_d;
        end
    end

    assign ex_fwd_cnt  = ex_cnt_q;
    assign mem_fwd_cnt = mem_cnt_q;
`else
    logic unused_cnt_ins;
    assign unused_cnt_ins = ^{clk, rst_n, cnt_en, cnt_clr};
    assign ex_fwd_cnt     = '0;
    assign mem_fwd_cnt    = '0;
`endif
endmodule

// File: tb/tb_forwarding_unit.sv
// Bench for forwarding_unit: spec vectors, counter scenarios and random
// stimulus against a producer-list reference model with saturating counts.

module tb_forwarding_unit;
    localparam int AW   = 2;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;
`ifdef FORWARDING_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] IDEX_rs, IDEX_rt, EXMEM_rd, MEMWB_rd;
    logic          EXMEM_RegWrite, MEMWB_RegWrite, cnt_en, cnt_clr;
    logic [1:0]    ForwardA, ForwardB;
    logic [CW-1:0] ex_fwd_cnt, mem_fwd_cnt;

    int total = 0;
    int bad   = 0;
    int ex_m  = 0;
    int mem_m = 0;

    forwarding_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .IDEX_rs(IDEX_rs), .IDEX_rt(IDEX_rt),
        .EXMEM_rd(EXMEM_rd), .MEMWB_rd(MEMWB_rd),
        .EXMEM_RegWrite(EXMEM_RegWrite), .MEMWB_RegWrite(MEMWB_RegWrite),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .ex_fwd_cnt(ex_fwd_cnt), .mem_fwd_cnt(mem_fwd_cnt)
    );

    always #5 clk = ~clk;

    // Producers listed youngest first; the first live writer of src is the source.
    function automatic logic [1:0] ref_sel(input logic [AW-1:0] s);
        logic [AW-1:0] rd [2];
        logic          we [2];
        logic [1:0]    code [2];
        rd   = '{EXMEM_rd, MEMWB_rd};
        we   = '{EXMEM_RegWrite, MEMWB_RegWrite};
        code = '{2'b10, 2'b01};
        for (int p = 0; p < 2; p++)
            if (we[p] && rd[p] != 0 && rd[p] == s) return code[p];
        return 2'b00;
    endfunction

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    // Apply what the counters should do at the coming rising edge.
    task automatic model_edge();
        logic [1:0] a, b;
        a = ref_sel(IDEX_rs);
        b = ref_sel(IDEX_rt);
        if (!PERF || !rst_n || cnt_clr) begin
            ex_m  = 0;
            mem_m = 0;
        end else if (cnt_en) begin
            ex_m  = sat(ex_m  + int'(a == 2'b10) + int'(b == 2'b10));
            mem_m = sat(mem_m + int'(a == 2'b01) + int'(b == 2'b01));
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input logic [AW-1:0] rs, rt, exrd, memrd,
                           input logic exw, memw);
        IDEX_rs = rs; IDEX_rt = rt; EXMEM_rd = exrd; MEMWB_rd = memrd;
        EXMEM_RegWrite = exw; MEMWB_RegWrite = memw;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cnt_en = 1'b1; cnt_clr = 1'b0;
        set_vec(2'b01, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0);
        #1;
        total++;
        if (ex_fwd_cnt !== '0 || mem_fwd_cnt !== '0) begin
            bad++;
            $display("FAIL reset_cnt: got ex=%0d mem=%0d want 0/0", ex_fwd_cnt, mem_fwd_cnt);
        end
        total++;
        if (ForwardA !== 2'b10 || ForwardB !== 2'b00) begin
            bad++;
            $display("FAIL sel_in_reset: got %b/%b want 10/00", ForwardA, ForwardB);
        end
        tick(); tick();
        total++;
        if (ex_fwd_cnt !== '0) begin
            bad++;
            $display("FAIL reset_hold: got ex=%0d want 0", ex_fwd_cnt);
        end
        rst_n = 1'b1;
        ex_m = 0; mem_m = 0;
    endtask

    task automatic test_sel_table();
        logic [AW-1:0] v [8][4];
        logic          w [8][2];
        logic [1:0]    ea [8], eb [8];
        v = '{'{2'b01,2'b00,2'b01,2'b01}, '{2'b00,2'b01,2'b01,2'b01},
              '{2'b11,2'b01,2'b01,2'b11}, '{2'b01,2'b10,2'b11,2'b10},
              '{2'b11,2'b01,2'b01,2'b11}, '{2'b01,2'b10,2'b11,2'b10},
              '{2'b10,2'b10,2'b10,2'b10}, '{2'b00,2'b00,2'b00,2'b00}};
        w = '{'{1,0}, '{1,0}, '{1,1}, '{1,1}, '{0,0}, '{0,0}, '{1,1}, '{1,1}};
        ea = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
        eb = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
        cnt_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_vec(v[i][0], v[i][1], v[i][2], v[i][3], w[i][0], w[i][1]);
            #1;
            total++;
            if (ForwardA !== ea[i] || ForwardB !== eb[i]) begin
                bad++;
                $display("FAIL sel_vec%0d: got %b/%b want %b/%b", i, ForwardA, ForwardB, ea[i], eb[i]);
            end
        end
        tick();
    endtask

    task automatic test_count();
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        cnt_en = 1'b1;
        set_vec(2'b01, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0);
        repeat (3) tick();
        cnt_en = 1'b0;
        total++;
        if (ex_fwd_cnt !== (PERF ? 4'd3 : 4'd0) || mem_fwd_cnt !== 4'd0) begin
            bad++;
            $display("FAIL count3: got ex=%0d mem=%0d want %0d/0", ex_fwd_cnt, mem_fwd_cnt, PERF ? 3 : 0);
        end
        // Hold with cnt_en low.
        repeat (2) tick();
        total++;
        if (ex_fwd_cnt !== CW'(ex_m)) begin
            bad++;
            $display("FAIL hold: got ex=%0d want %0d", ex_fwd_cnt, ex_m);
        end
    endtask

    task automatic test_clear();
        cnt_en = 1'b1; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0; cnt_en = 1'b0;
        total++;
        if (ex_fwd_cnt !== '0 || mem_fwd_cnt !== '0) begin
            bad++;
            $display("FAIL clear: got ex=%0d mem=%0d want 0/0", ex_fwd_cnt, mem_fwd_cnt);
        end
    endtask

    task automatic test_saturate();
        set_vec(2'b10, 2'b10, 2'b10, 2'b01, 1'b1, 1'b0);
        cnt_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (ex_fwd_cnt !== CW'(ex_m)) begin
                bad++;
                $display("FAIL sat_step%0d: got ex=%0d want %0d", i, ex_fwd_cnt, ex_m);
            end
        end
        cnt_en = 1'b0;
        total++;
        if (ex_fwd_cnt !== (PERF ? 4'd15 : 4'd0)) begin
            bad++;
            $display("FAIL sat_final: got ex=%0d want %0d", ex_fwd_cnt, PERF ? 15 : 0);
        end
    endtask

    task automatic test_reset_mid();
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        set_vec(2'b11, 2'b01, 2'b01, 2'b11, 1'b1, 1'b1);
        cnt_en = 1'b1;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (ex_fwd_cnt !== '0 || mem_fwd_cnt !== '0) begin
            bad++;
            $display("FAIL reset_mid: got ex=%0d mem=%0d want 0/0", ex_fwd_cnt, mem_fwd_cnt);
        end
        total++;
        if (ForwardA !== 2'b01 || ForwardB !== 2'b10) begin
            bad++;
            $display("FAIL reset_mid_sel: got %b/%b want 01/10", ForwardA, ForwardB);
        end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (ex_fwd_cnt !== CW'(ex_m) || mem_fwd_cnt !== CW'(mem_m)) begin
            bad++;
            $display("FAIL post_reset: got ex=%0d mem=%0d want %0d/%0d", ex_fwd_cnt, mem_fwd_cnt, ex_m, mem_m);
        end
    endtask

    task automatic test_random();
        logic [1:0] ea, eb;
        for (int i = 0; i < 300; i++) begin
            set_vec(AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
                    1'($urandom), 1'($urandom));
            cnt_en  = ($urandom_range(0, 3) != 0);
            cnt_clr = ($urandom_range(0, 11) == 0);
            #1;
            ea = ref_sel(IDEX_rs);
            eb = ref_sel(IDEX_rt);
            total++;
            if (ForwardA !== ea || ForwardB !== eb) begin
                bad++;
                $display("FAIL rnd_sel%0d: got %b/%b want %b/%b", i, ForwardA, ForwardB, ea, eb);
            end
            tick();
            total++;
            if (ex_fwd_cnt !== CW'(ex_m) || mem_fwd_cnt !== CW'(mem_m)) begin
                bad++;
                $display("FAIL rnd_cnt%0d: got ex=%0d mem=%0d want %0d/%0d", i, ex_fwd_cnt, mem_fwd_cnt, ex_m, mem_m);
            end
        end
        cnt_en = 1'b0; cnt_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sel_table();
        test_count();
        test_clear();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
